// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory arbiter.
// Build option: DMEM_ARB_ALIGN_CHECK_EN enables misaligned-access checking.
package dmem_pkg;

    localparam int DMEM_AW    = 10;
    localparam int DMEM_WORDS = 1 << DMEM_AW;

    typedef enum logic {
        IDLE,
        RESP
    } arb_state_t;

    function automatic logic [29:0] word_addr(input logic [31:0] byte_addr);
        return byte_addr[31:2];
    endfunction

endpackage

// File: rtl/dmem_starve_cnt.sv
// Saturating count of consecutive cycles the EXT port was denied memory.
module dmem_starve_cnt
#(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);

    localparam int W = (MAX < 1) ? 1 : $clog2(MAX + 1);
    localparam logic [W-1:0] MAXV = W'(MAX);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && cnt_q != MAXV) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat_o = (cnt_q == MAXV);

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port D_RAM arbiter: CPU priority, EXT forced in after starvation.
// Build option: DMEM_ARB_ALIGN_CHECK_EN suppresses misaligned writes.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int AW         = 10,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_rd,
    input  logic          cpu_wr,
    input  logic [31:0]   cpu_addr,
    input  logic [31:0]   cpu_wdata,
    output logic [31:0]   cpu_rdata,
    output logic          cpu_stall,
    input  logic          ext_req,
    input  logic          ext_we,
    input  logic [31:0]   ext_addr,
    input  logic [31:0]   ext_wdata,
    output logic          ext_ack,
    output logic [31:0]   ext_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic          misalign_err
);

    arb_state_t  state_q;
    logic        cpu_busy;
    logic        sat;
    logic        grant_ext;
    logic        cpu_go;
    logic        acc_en;
    logic        acc_we;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;

    assign cpu_busy  = cpu_rd | cpu_wr;
    assign grant_ext = !reset && state_q == IDLE && ext_req
                       && (!cpu_busy || sat);
    assign cpu_go    = !reset && cpu_busy && !grant_ext;

    assign acc_en    = grant_ext | cpu_go;
    assign acc_addr  = grant_ext ? ext_addr  : cpu_addr;
    assign acc_wdata = grant_ext ? ext_wdata : cpu_wdata;
    assign acc_we    = grant_ext ? ext_we    : cpu_wr;

    dmem_starve_cnt #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk   (clk),
        .reset (reset),
        .inc_i (!reset && state_q == IDLE && ext_req
                && cpu_busy && !grant_ext),
        .clr_i (grant_ext | !ext_req),
        .sat_o (sat)
    );

    // RESP lasts exactly one cycle; it is the EXT ack slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else if (state_q == RESP) begin
            state_q <= IDLE;
        end else if (grant_ext) begin
            state_q <= RESP;
        end
    end

    assign cpu_stall = grant_ext & cpu_busy;
    assign cpu_rdata = mem_rdata;
    assign ext_ack   = !reset && state_q == RESP;
    assign ext_rdata = reset ? '0 : mem_rdata;
    assign mem_en    = acc_en;
    assign mem_addr  = reset ? '0 : AW'(word_addr(acc_addr));
    assign mem_wdata = reset ? '0 : acc_wdata;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
    logic misal;
    logic misalign_q;

    assign misal  = acc_en && acc_addr[1:0] != 2'b00;
    assign mem_we = acc_en && acc_we && !misal;

    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_q <= 1'b0;
        end else if (misal) begin
            misalign_q <= 1'b1;
        end
    end

    assign misalign_err = misalign_q;
`else
    assign mem_we       = acc_en && acc_we;
    assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised scoreboard bench for dmem_arbiter with a behavioural model.
module tb_dmem_arbiter;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;
    localparam int SMAX  = 4;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          cpu_rd = 1'b0;
    logic          cpu_wr = 1'b0;
    logic [31:0]   cpu_addr = '0;
    logic [31:0]   cpu_wdata = '0;
    logic [31:0]   cpu_rdata;
    logic          cpu_stall;
    logic          ext_req = 1'b0;
    logic          ext_we = 1'b0;
    logic [31:0]   ext_addr = '0;
    logic [31:0]   ext_wdata = '0;
    logic          ext_ack;
    logic [31:0]   ext_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          misalign_err;

    logic [31:0]   z_cpu_rdata;
    logic          z_stall;
    logic          z_ext_ack;
    logic [31:0]   z_ext_rdata;
    logic          z_mem_en;
    logic          z_mem_we;
    logic [AW-1:0] z_mem_addr;
    logic [31:0]   z_mem_wdata;
    logic          z_mis;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(AW), .STARVE_MAX(SMAX)) u_dut (
        .clk(clk), .reset(reset),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .ext_req(ext_req), .ext_we(ext_we),
        .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_ack(ext_ack), .ext_rdata(ext_rdata),
        .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .misalign_err(misalign_err)
    );

    dmem_arbiter #(.AW(AW), .STARVE_MAX(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(z_cpu_rdata), .cpu_stall(z_stall),
        .ext_req(ext_req), .ext_we(ext_we),
        .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_ack(z_ext_ack), .ext_rdata(z_ext_rdata),
        .mem_en(z_mem_en), .mem_we(z_mem_we),
        .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata),
        .mem_rdata(32'h0), .misalign_err(z_mis)
    );

    // D_RAM with registered read port
    logic [31:0] ram [DEPTH];
    always @(posedge clk) begin
        if (mem_en) begin
            mem_rdata <= ram[mem_addr];
            if (mem_we) ram[mem_addr] = mem_wdata;
        end
    end

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          rd;
        logic [31:0] d;
    } ext_exp_t;

    ext_exp_t    extq[$];
    logic [31:0] cpuq[$];
    logic [31:0] ref_mem [DEPTH];
    int          m_starve  = 0;
    bit          m_resp    = 1'b0;
    bit          m_mis     = 1'b0;
    bit          ext_done  = 1'b0;
    bit          m_stalled = 1'b0;
    bit          rd_pend   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) & 32'(DEPTH - 1));
    endfunction

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 31)) << 2);
        if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
        return a;
    endfunction

    task automatic cpu_set(input bit rd, input bit wr,
                           input logic [31:0] a, input logic [31:0] d);
        cpu_rd = rd; cpu_wr = wr; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic ext_set(input bit req, input bit we,
                           input logic [31:0] a, input logic [31:0] d);
        ext_req = req; ext_we = we; ext_addr = a; ext_wdata = d;
    endtask

    // One bus cycle: inputs already applied; model decides who owns memory.
    task automatic cyc();
        bit          busy, grant, mis, is_wr, is_rd;
        logic [31:0] a, d;
        ext_exp_t    e;
        #1;
        busy  = cpu_rd | cpu_wr;
        grant = !m_resp && ext_req && (!busy || m_starve >= SMAX);
        chk("cpu_stall", cpu_stall, 32'(grant && busy));
        chk("ext_ack", ext_ack, 32'(m_resp));
        chk("misalign_err", misalign_err, 32'(m_mis));
        if (grant || busy) begin
            a     = grant ? ext_addr  : cpu_addr;
            d     = grant ? ext_wdata : cpu_wdata;
            is_wr = grant ? ext_we    : cpu_wr;
            is_rd = grant ? !ext_we   : cpu_rd;
            mis   = ALIGN && (a[1:0] != 2'b00);
            if (grant) begin
                e.rd = is_rd;
                e.d  = ref_mem[widx(a)];
                extq.push_back(e);
            end else if (is_rd) begin
                cpuq.push_back(ref_mem[widx(a)]);
            end
            if (is_wr && !mis) ref_mem[widx(a)] = d;
            if (mis) m_mis = 1'b1;
        end
        if (grant || !ext_req) m_starve = 0;
        else if (!m_resp && busy && m_starve < SMAX) m_starve++;
        ext_done  = m_resp;
        m_stalled = grant && busy;
        m_resp    = grant;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        ext_exp_t e;
        if (reset) begin
            rd_pend <= 1'b0;
        end else begin
            if (rd_pend) begin
                if (cpuq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL cpu_rdata: unexpected data %h", cpu_rdata);
                end else begin
                    chk("cpu_rdata", cpu_rdata, cpuq.pop_front());
                end
            end
            rd_pend <= cpu_rd && !cpu_stall;
            if (ext_ack) begin
                if (extq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL ext_ack: spurious ack, rdata %h", ext_rdata);
                end else begin
                    e = extq.pop_front();
                    if (e.rd) chk("ext_rdata", ext_rdata, e.d);
                end
            end
        end
    end

    initial begin
        int stall_at, nst, r;
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]     = '0;
            ref_mem[i] = '0;
        end

        // reset with live requests on both ports
        cpu_set(0, 1, 32'h44, 32'h1111);
        ext_set(1, 1, 32'h48, 32'h2222);
        repeat (2) @(posedge clk);
        #2;
        chk("rst_ext_ack", ext_ack, 0);
        chk("rst_cpu_stall", cpu_stall, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_ext_rdata", ext_rdata, 0);
        chk("rst_misalign", misalign_err, 0);
        cpu_set(0, 0, 0, 0);
        ext_set(0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // CPU only
        cpu_set(0, 1, 32'h40, 32'hDEADBEEF);
        #1;
        chk("cpu_wr_mem_addr", mem_addr, 32'h10);
        chk("cpu_wr_mem_we", mem_we, 1);
        cyc();
        cpu_set(1, 0, 32'h40, 0);
        cyc();
        cpu_set(0, 0, 0, 0);
        cyc();

        // EXT only, back-to-back requests
        ext_set(1, 1, 32'h80, 32'h12345678);
        cyc();
        cyc();
        ext_set(1, 0, 32'h80, 0);
        cyc();
        cyc();
        ext_set(0, 0, 0, 0);
        cyc();

        // starvation: CPU stores every cycle
        ext_set(1, 1, 32'h100, 32'hA0A00001);
        stall_at = -1;
        nst = 0;
        for (int k = 0; k < 8; k++) begin
            if (ext_done) ext_req = 1'b0;
            if (!m_stalled) cpu_set(0, 1, 32'h200 + 32'(k * 4), 32'h5000 + 32'(k));
            #1;
            if (cpu_stall) begin
                nst++;
                stall_at = k;
            end
            cyc();
        end
        chk("forced_grant_cycle", stall_at, 4);
        chk("forced_stall_count", nst, 1);
        cpu_set(1, 0, 32'h210, 0);
        cyc();
        cpu_set(1, 0, 32'h100, 0);
        cyc();
        cpu_set(0, 0, 0, 0);
        cyc();
        cyc();

        // simultaneous CPU write and EXT request, counter at 0
        ext_set(1, 0, 32'h200, 0);
        cpu_set(0, 1, 32'h300, 32'h77770000);
        #1;
        chk("contend_mem_addr", mem_addr, 32'hC0);
        chk("contend_s0_stall", z_stall, 1);
        chk("contend_s0_addr", z_mem_addr, 32'h80);
        cyc();
        cpu_set(0, 0, 0, 0);
        cyc();
        cyc();
        ext_set(0, 0, 0, 0);
        cyc();

        // reset during the ack cycle
        ext_set(1, 1, 32'h3F0, 32'hA5A55A5A);
        cyc();
        reset = 1'b1;
        #1;
        chk("rst_resp_ack", ext_ack, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        ext_set(0, 0, 0, 0);
        extq.delete();
        cpuq.delete();
        m_resp = 1'b0; m_starve = 0; m_mis = 1'b0; ext_done = 1'b0;
        #1;
        chk("rst_resp_idle", ext_ack, 0);
        cpu_set(1, 0, 32'h3F0, 0);
        cyc();
        cpu_set(0, 0, 0, 0);
        cyc();

        // misaligned CPU store
        cpu_set(0, 1, 32'h40, 32'h0BADF00D);
        cyc();
        cpu_set(0, 1, 32'h42, 32'hCAFEF00D);
        cyc();
        cpu_set(1, 0, 32'h40, 0);
        cyc();
        cpu_set(0, 0, 0, 0);
        cyc();
        chk("misalign_flag", misalign_err, 32'(ALIGN));

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            if (!m_stalled) begin
                r = int'($urandom_range(0, 3));
                cpu_set(r == 1, r == 2, rnd_addr(), $urandom);
            end
            if (!ext_req || ext_done) begin
                if ($urandom_range(0, 2) == 0)
                    ext_set(1, 1'($urandom_range(0, 1)), rnd_addr(), $urandom);
                else
                    ext_req = 1'b0;
            end
            cyc();
        end

        // drain
        cpu_set(0, 0, 0, 0);
        for (int n = 0; n < 6 && ext_req; n++) begin
            if (ext_done) ext_req = 1'b0;
            else cyc();
        end
        ext_req = 1'b0;
        cyc();
        cyc();
        chk("extq_empty", extq.size(), 0);
        chk("cpuq_empty", cpuq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
